// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: ALU opcodes, forwarding selects,
// branch funct3 codes and the default datapath widths.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REGW_DEFAULT = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the EX stage. Arithmetic wraps modulo 2^XLEN;
// unused opcodes produce zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  // Select the operation result; anything undefined yields zero.
  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_XOR: Result = SrcA ^ SrcB;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, branch/jump resolution, branch
// target, and the EX/MEM pipeline register.
// Optional feature: define BRANCH_EXT_EN for the full funct3 branch
// comparator; otherwise branches are BEQ-only using the ALU zero flag.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int REGW = REGW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Operand A forwarding; select 11 falls back to the register file value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  // Operand B forwarding; this forwarded value is also the store data.
  always_comb begin
    write_data = RD2_E;
    case (ForwardB_E)
      FWD_WB:  write_data = ResultW;
      FWD_MEM: write_data = ALU_ResultM;
      default: write_data = RD2_E;
    endcase
  end

  assign src_b     = ALUSrcE ? Imm_Ext_E : write_data;
  assign PCTargetE = PCE + Imm_Ext_E;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (zero)
  );

`ifdef BRANCH_EXT_EN
  logic taken;
  logic unused_zero;
  assign unused_zero = zero;

  // Dedicated comparator decides the branch condition from funct3.
  always_comb begin
    taken = 1'b0;
    case (Funct3E)
      BR_BEQ:  taken = (src_a == write_data);
      BR_BNE:  taken = (src_a != write_data);
      BR_BLT:  taken = ($signed(src_a) <  $signed(write_data));
      BR_BGE:  taken = ($signed(src_a) >= $signed(write_data));
      BR_BLTU: taken = (src_a <  write_data);
      BR_BGEU: taken = (src_a >= write_data);
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE = (BranchE & taken) | JumpE;
`else
  logic unused_funct3;
  assign unused_funct3 = ^Funct3E;

  assign PCSrcE = (BranchE & zero) | JumpE;
`endif

  // EX/MEM pipeline register, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: expected EX/MEM contents are queued
// when an instruction is driven and compared after the capturing edge.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rw, mw, rs, asrc, br, jp;
    logic [2:0]  ctl, f3;
    logic [31:0] rd1, rd2, imm, pc, pc4, resw;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
  } stim_t;

  typedef struct {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] pc4, wd, alu;
  } exp_t;

  exp_t  sbq[$];
  stim_t s;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  function automatic stim_t blank();
    stim_t b;
    b.rw = 0; b.mw = 0; b.rs = 0; b.asrc = 0; b.br = 0; b.jp = 0;
    b.ctl = 3'b000; b.f3 = 3'b000;
    b.rd1 = 0; b.rd2 = 0; b.imm = 0; b.pc = 0; b.pc4 = 0; b.resw = 0;
    b.rd = 0; b.fa = 2'b00; b.fb = 2'b00;
    return b;
  endfunction

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input stim_t d);
    RegWriteE = d.rw; MemWriteE = d.mw; ResultSrcE = d.rs; ALUSrcE = d.asrc;
    BranchE = d.br; JumpE = d.jp; ALUControlE = d.ctl; Funct3E = d.f3;
    RD1_E = d.rd1; RD2_E = d.rd2; Imm_Ext_E = d.imm; RD_E = d.rd;
    PCE = d.pc; PCPlus4E = d.pc4; ForwardA_E = d.fa; ForwardB_E = d.fb;
    ResultW = d.resw;
  endtask

  task automatic applyStimulus(input stim_t d, input logic [31:0] expAlu, input logic [31:0] expWd);
    exp_t e;
    driveInputs(d);
    e.rw = d.rw; e.mw = d.mw; e.rs = d.rs; e.rd = d.rd; e.pc4 = d.pc4;
    e.wd = expWd; e.alu = expAlu;
    sbq.push_back(e);
  endtask

  task automatic checkComb(input string tag, input logic expSrc, input logic [31:0] expTgt);
    #1;
    checkField({tag, ".PCSrcE"}, {31'b0, PCSrcE}, {31'b0, expSrc});
    checkField({tag, ".PCTargetE"}, PCTargetE, expTgt);
  endtask

  task automatic checkZero(input string tag);
    checkField({tag, ".RegWriteM"}, {31'b0, RegWriteM}, 32'd0);
    checkField({tag, ".MemWriteM"}, {31'b0, MemWriteM}, 32'd0);
    checkField({tag, ".ResultSrcM"}, {31'b0, ResultSrcM}, 32'd0);
    checkField({tag, ".RD_M"}, {27'b0, RD_M}, 32'd0);
    checkField({tag, ".PCPlus4M"}, PCPlus4M, 32'd0);
    checkField({tag, ".WriteDataM"}, WriteDataM, 32'd0);
    checkField({tag, ".ALU_ResultM"}, ALU_ResultM, 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      checkField({tag, ".RegWriteM"}, {31'b0, RegWriteM}, {31'b0, e.rw});
      checkField({tag, ".MemWriteM"}, {31'b0, MemWriteM}, {31'b0, e.mw});
      checkField({tag, ".ResultSrcM"}, {31'b0, ResultSrcM}, {31'b0, e.rs});
      checkField({tag, ".RD_M"}, {27'b0, RD_M}, {27'b0, e.rd});
      checkField({tag, ".PCPlus4M"}, PCPlus4M, e.pc4);
      checkField({tag, ".WriteDataM"}, WriteDataM, e.wd);
      checkField({tag, ".ALU_ResultM"}, ALU_ResultM, e.alu);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    driveInputs(blank());

    // Held reset with random inputs toggling: outputs must stay zero.
    for (int i = 0; i < 4; i++) begin
      s = blank();
      s.rw = 1'($urandom); s.mw = 1'($urandom); s.rs = 1'($urandom);
      s.asrc = 1'($urandom); s.ctl = 3'($urandom);
      s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
      s.rd = 5'($urandom); s.pc4 = $urandom; s.resw = $urandom;
      driveInputs(s);
      tick();
      checkZero("hold_reset");
    end
    rst = 1'b1;

    // ADD with immediate.
    s = blank();
    s.rd1 = 5; s.imm = 7; s.asrc = 1; s.ctl = 3'b000; s.rd = 3; s.rw = 1;
    s.rd2 = 32'h11; s.pc4 = 32'h204;
    applyStimulus(s, 32'd12, 32'h11);
    tick(); checkOutput("add");

    // Forward A from ALU_ResultM (12) minus RD2 (4).
    s = blank();
    s.rd1 = 100; s.fa = 2'b10; s.rd2 = 4; s.ctl = 3'b001; s.rd = 4; s.rw = 1;
    s.pc4 = 32'h208;
    applyStimulus(s, 32'd8, 32'd4);
    tick(); checkOutput("fwdA_mem_sub");

    // Forward B from writeback into a store.
    s = blank();
    s.rd1 = 1; s.rd2 = 32'h55; s.fb = 2'b01; s.resw = 32'hDEADBEEF;
    s.mw = 1; s.ctl = 3'b000; s.pc4 = 32'h20C;
    applyStimulus(s, 32'hDEADBEF0, 32'hDEADBEEF);
    tick(); checkOutput("fwdB_wb_store");

    // Forward select 11 acts like 00; writeback value must be ignored.
    s = blank();
    s.rd1 = 20; s.fa = 2'b11; s.resw = 999; s.asrc = 1; s.imm = 2;
    s.ctl = 3'b000; s.rs = 1; s.rw = 1; s.rd = 31;
    applyStimulus(s, 32'd22, 32'd0);
    tick(); checkOutput("fwdA_11");

    // Logic ops and SLT signedness.
    s = blank(); s.rd1 = 32'hF0F0_1234; s.rd2 = 32'h0FF0_FF00; s.ctl = 3'b010;
    applyStimulus(s, 32'h00F0_1200, 32'h0FF0_FF00); tick(); checkOutput("and");
    s.ctl = 3'b011;
    applyStimulus(s, 32'hFFF0_FF34, 32'h0FF0_FF00); tick(); checkOutput("or");
    s.ctl = 3'b100;
    applyStimulus(s, 32'hFF00_ED34, 32'h0FF0_FF00); tick(); checkOutput("xor");
    s = blank(); s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.ctl = 3'b101;
    applyStimulus(s, 32'd1, 32'd1); tick(); checkOutput("slt_neg");
    s.rd1 = 1; s.rd2 = 32'hFFFF_FFFF;
    applyStimulus(s, 32'd0, 32'hFFFF_FFFF); tick(); checkOutput("slt_pos");
    s.ctl = 3'b110;
    applyStimulus(s, 32'd0, 32'hFFFF_FFFF); tick(); checkOutput("op110");

    // BEQ taken, backward target.
    s = blank();
    s.rd1 = 9; s.rd2 = 9; s.br = 1; s.ctl = 3'b001; s.pc = 32'h100;
    s.imm = 32'hFFFF_FFF0; s.pc4 = 32'h104;
    applyStimulus(s, 32'd0, 32'd9);
    checkComb("beq_taken", 1'b1, 32'h0000_00F0);
    tick(); checkOutput("beq_taken_m");

    // BEQ not taken.
    s.rd2 = 8;
    applyStimulus(s, 32'd1, 32'd8);
    checkComb("beq_not", 1'b0, 32'h0000_00F0);
    tick(); checkOutput("beq_not_m");

    // Funct3=BNE with equal operands.
    s.rd2 = 9; s.f3 = 3'b001;
    applyStimulus(s, 32'd0, 32'd9);
`ifdef BRANCH_EXT_EN
    checkComb("f3_bne_eq", 1'b0, 32'h0000_00F0);
`else
    checkComb("f3_bne_eq", 1'b1, 32'h0000_00F0);
`endif
    tick(); checkOutput("f3_bne_eq_m");

    // Signed vs unsigned less-than on -1 vs 1.
    s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.f3 = 3'b100;
    applyStimulus(s, 32'hFFFF_FFFE, 32'd1);
`ifdef BRANCH_EXT_EN
    checkComb("f3_blt", 1'b1, 32'h0000_00F0);
`else
    checkComb("f3_blt", 1'b0, 32'h0000_00F0);
`endif
    tick(); checkOutput("f3_blt_m");
    s.f3 = 3'b110;
    applyStimulus(s, 32'hFFFF_FFFE, 32'd1);
    checkComb("f3_bltu", 1'b0, 32'h0000_00F0);
    tick(); checkOutput("f3_bltu_m");

    // Jump with target wrap, plus branch-not-taken alongside jump.
    s = blank();
    s.jp = 1; s.pc = 32'hFFFF_FFFC; s.imm = 8; s.pc4 = 32'h0000_0000;
    s.rw = 1; s.rd = 1; s.rd1 = 3; s.rd2 = 2; s.br = 1; s.ctl = 3'b001;
    applyStimulus(s, 32'd1, 32'd2);
    checkComb("jal_wrap", 1'b1, 32'h0000_0004);
    tick(); checkOutput("jal_wrap_m");
    s.pc4 = 32'h1234_5678; s.br = 0;
    applyStimulus(s, 32'd1, 32'd2);
    tick(); checkOutput("jal_pc4");

    // Asynchronous reset asserted mid-cycle discards the in-flight data.
    s = blank(); s.rd1 = 77; s.rw = 1; s.rd = 9; s.pc4 = 32'h40;
    applyStimulus(s, 32'd77, 32'd0);
    tick();
    #2 rst = 1'b0;
    #1 checkZero("async_reset");
    sbq.delete();
    tick();
    checkZero("async_reset_edge");
    rst = 1'b1;

    // First capture after reset release.
    s = blank(); s.rd1 = 40; s.imm = 2; s.asrc = 1; s.rw = 1; s.rd = 7;
    s.pc4 = 32'h88;
    applyStimulus(s, 32'd42, 32'd0);
    tick(); checkOutput("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute (EX) stage of the 5-stage RISC-V pipeline, between the decode stage and the memory stage.
- Selects forwarded operands, runs the ALU, resolves branches and jumps, and computes the branch target.
- Registers all memory-stage inputs in the EX/MEM pipeline register.
- PCSrcE and PCTargetE go combinationally to fetch. All *M outputs drive the memory stage directly.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE  in  1 each  decoded controls
- ALUControlE  in  3  ALU operation
- Funct3E  in  3  branch condition; used only with BRANCH_EXT_EN
- RD1_E, RD2_E  in  XLEN  register-file operands
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  REGW  destination register
- PCE, PCPlus4E  in  XLEN  instruction PC and PC+4
- ForwardA_E, ForwardB_E  in  2  forward selects from the hazard unit
- ResultW  in  XLEN  writeback-stage result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  PCE+Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered controls
- RD_M  out  REGW  registered destination
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN  registered data

Behaviour:
- Reset: rst is asynchronous and active-low; clock is clk. On rst=0 every registered output (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM) clears to 0 immediately, without waiting for a clock edge.
- Reset mid-operation discards the in-flight EX/MEM contents. The first capture happens on the first posedge clk after rst rises.
- Forward mux A (SrcAE), selected by ForwardA_E:
  - 00: RD1_E
  - 01: ResultW
  - 10: ALU_ResultM (this block's own registered output)
  - 11: behaves as 00
- Forward mux B (WriteDataE) uses ForwardB_E and the same encoding on RD2_E.
- SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU encoding; all arithmetic is modulo 2^XLEN with no overflow flag:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed, result 0 or 1)
  - 110, 111: result 0
- ZeroE = (ALUResultE == 0).
- Branch, default build: PCSrcE = (BranchE & ZeroE) | JumpE. This is BEQ only; decode sets ALUControlE=SUB for branches.
- PCTargetE = PCE + Imm_Ext_E, truncated to XLEN (wraps at 2^32).
- Pipeline register: one cycle latency. On every posedge clk with rst=1, the *M outputs capture the *E values of that cycle. WriteDataM captures the forwarded WriteDataE, not RD2_E.
- No stall/flush inputs. Bubbles arrive as all-zero controls from the ID/EX register.
- Simultaneous BranchE and JumpE: JumpE wins, so PCSrcE=1.

Optional Feature:
- Macro: BRANCH_EXT_EN.
- Defined: a dedicated comparator on SrcAE and WriteDataE, separate from the ALU result, sets the taken condition from Funct3E:
  - 000 BEQ
  - 001 BNE
  - 100 BLT
  - 101 BGE
  - 110 BLTU
  - 111 BGEU
  - 010, 011: not taken
  - PCSrcE = (BranchE & taken) | JumpE.
- Not defined: Funct3E is ignored and the BEQ-only rule applies.

Decomposition:
- Shared package/include riscv_pkg holds:
  - ALU_ADD..ALU_SLT opcode constants
  - FWD_RF/FWD_WB/FWD_MEM select constants
  - BR_* funct3 constants
  - XLEN default
- One sub-module, alu: SrcA, SrcB, ALUControl -> Result, Zero. It is purely combinational and is instantiated once.

Test Plan:
- Reset: hold rst=0 with random inputs toggling. All *M outputs stay 0. Assert rst=0 asynchronously mid-cycle: outputs clear before the next edge.
- ADD pipeline: RD1_E=5, Imm_Ext_E=7, ALUSrcE=1, ALUControlE=000, RD_E=3, RegWriteE=1. After one clk: ALU_ResultM=12, RD_M=3, RegWriteM=1.
- Forwarding:
  - ForwardA_E=10 with ALU_ResultM=12, RD2_E=4, SUB gives ALU_ResultM=8 next cycle.
  - ForwardB_E=01, ResultW=0xDEADBEEF, MemWriteE=1 gives WriteDataM=0xDEADBEEF.
- BEQ: RD1_E=RD2_E=9, BranchE=1, SUB, PCE=0x100, Imm_Ext_E=0xFFFFFFF0. Expect PCSrcE=1, PCTargetE=0xF0. With RD2_E=8, PCSrcE=0.
- Jump and wrap: JumpE=1, PCE=0xFFFFFFFC, Imm=8. Expect PCSrcE=1, PCTargetE=0x4, PCPlus4M = PCPlus4E one cycle later.
- BRANCH_EXT_EN build: Funct3E=100, SrcA=0xFFFFFFFF, SrcB=1. Expect taken (signed). With Funct3E=110, not taken (unsigned). Default build with Funct3E=001 and equal operands: taken (Funct3E ignored).
